pixel_write_scheduler: RTL

Shares the single 160x120 pixel-write port of the VGA adapter between several drawing requesters (background clear, note renderer, score/HUD painter, flame effects). Each requester submits a filled-rectangle command; the block grants commands round-robin and scans each granted rectangle into one pixel write per clock, clipping to the screen. It sits between the game logic and the VGA adapter's x/y/colour/plot inputs.

---
 rtl/bbq_gfx_pkg.sv | 23 ++
 rtl/pixel_write_scheduler_if.sv | 34 +++
 rtl/pixel_write_scheduler_rr_arbiter.sv | 32 +++
 rtl/pixel_write_scheduler.sv | 127 ++++++++++++
 4 files changed

// File: rtl/bbq_gfx_pkg.sv
// Shared graphics definitions for the pixel-write path: screen geometry,
// scheduler state encoding and the rectangle command record.
package bbq_gfx_pkg;

    localparam int unsigned COORD_W  = 8;
    localparam int unsigned COLOUR_W = 9;
    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    typedef enum logic {
        IDLE,
        DRAW
    } sched_state_e;

    typedef struct packed {
        logic [COORD_W-1:0]  x0;
        logic [COORD_W-1:0]  y0;
        logic [COORD_W-1:0]  w;
        logic [COORD_W-1:0]  h;
        logic [COLOUR_W-1:0] colour;
    } rect_cmd_t;

endpackage

// File: rtl/pixel_write_scheduler_if.sv
// Requester command bus plus VGA pixel-write bus around the scheduler.
// master = game logic / adapter side, slave = scheduler.
interface pixel_write_scheduler_if #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned COORD_W  = bbq_gfx_pkg::COORD_W,
    parameter int unsigned COLOUR_W = bbq_gfx_pkg::COLOUR_W
);
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*COORD_W-1:0]  req_x0;
    logic [NUM_REQ*COORD_W-1:0]  req_y0;
    logic [NUM_REQ*COORD_W-1:0]  req_w;
    logic [NUM_REQ*COORD_W-1:0]  req_h;
    logic [NUM_REQ*COLOUR_W-1:0] req_colour;
    logic [COORD_W-1:0]          x_out;
    logic [COORD_W-1:0]          y_out;
    logic [COLOUR_W-1:0]         colour_out;
    logic                        plot_out;
    logic                        busy;
    logic [ID_W-1:0]             grant_id;

    modport master (
        output req_valid, req_x0, req_y0, req_w, req_h, req_colour,
        input  req_ready, x_out, y_out, colour_out, plot_out, busy, grant_id
    );

    modport slave (
        input  req_valid, req_x0, req_y0, req_w, req_h, req_colour,
        output req_ready, x_out, y_out, colour_out, plot_out, busy, grant_id
    );

endinterface

// File: rtl/pixel_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request searching upward
// from last_grant+1 with wrap. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IW'((32'(last_grant) + i) % N);
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/pixel_write_scheduler.sv
// Round-robin scheduler that scans granted fill-rectangle commands into one
// clipped pixel write per clock for the VGA adapter.
module pixel_write_scheduler
    import bbq_gfx_pkg::rect_cmd_t, bbq_gfx_pkg::sched_state_e, bbq_gfx_pkg::IDLE,
           bbq_gfx_pkg::DRAW;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned COORD_W  = bbq_gfx_pkg::COORD_W,
    parameter int unsigned COLOUR_W = bbq_gfx_pkg::COLOUR_W,
    parameter int unsigned SCREEN_W = bbq_gfx_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = bbq_gfx_pkg::SCREEN_H
) (
    input  logic                     clk,
    input  logic                     reset,
    pixel_write_scheduler_if.slave   bus
);

    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [COORD_W:0] SCR_W = (COORD_W + 1)'(SCREEN_W);
    localparam logic [COORD_W:0] SCR_H = (COORD_W + 1)'(SCREEN_H);

    sched_state_e       state_q;
    rect_cmd_t          cmd_q;
    rect_cmd_t          req_cmd;
    logic [COORD_W-1:0] cx_q, cy_q;
    logic [COORD_W-1:0] nx, ny;
    logic [ID_W-1:0]    last_grant_q;
    logic [ID_W-1:0]    win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic               last_px;
    logic [COORD_W:0]   sum_x, sum_y;
    logic               in_screen;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .enable     (state_q == IDLE),
        .grant      (win_onehot),
        .idx        (win_idx)
    );

    assign bus.req_ready = win_onehot;

    always_comb begin
        req_cmd.x0     = bus.req_x0[32'(win_idx)*COORD_W +: COORD_W];
        req_cmd.y0     = bus.req_y0[32'(win_idx)*COORD_W +: COORD_W];
        req_cmd.w      = bus.req_w[32'(win_idx)*COORD_W +: COORD_W];
        req_cmd.h      = bus.req_h[32'(win_idx)*COORD_W +: COORD_W];
        req_cmd.colour = bus.req_colour[32'(win_idx)*COLOUR_W +: COLOUR_W];
    end

    // cx/cy track the pixel currently on the outputs; nx/ny is the one to emit next.
    always_comb begin
        last_px = (cx_q == cmd_q.w - COORD_W'(1)) && (cy_q == cmd_q.h - COORD_W'(1));
        if (cx_q == cmd_q.w - COORD_W'(1)) begin
            nx = '0;
            ny = cy_q + COORD_W'(1);
        end else begin
            nx = cx_q + COORD_W'(1);
            ny = cy_q;
        end
        if (state_q == IDLE) begin
            sum_x = {1'b0, req_cmd.x0};
            sum_y = {1'b0, req_cmd.y0};
        end else begin
            sum_x = {1'b0, cmd_q.x0} + {1'b0, nx};
            sum_y = {1'b0, cmd_q.y0} + {1'b0, ny};
        end
        in_screen = (sum_x < SCR_W) && (sum_y < SCR_H);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cmd_q          <= '0;
            cx_q           <= '0;
            cy_q           <= '0;
            last_grant_q   <= ID_W'(NUM_REQ - 1);
            bus.x_out      <= '0;
            bus.y_out      <= '0;
            bus.colour_out <= '0;
            bus.plot_out   <= 1'b0;
            bus.busy       <= 1'b0;
            bus.grant_id   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    bus.plot_out <= 1'b0;
                    if (|win_onehot) begin
                        cmd_q        <= req_cmd;
                        bus.grant_id <= win_idx;
                        last_grant_q <= win_idx;
                        cx_q         <= '0;
                        cy_q         <= '0;
                        // Empty rectangles are consumed without touching the pixel bus.
                        if (req_cmd.w != '0 && req_cmd.h != '0) begin
                            state_q        <= DRAW;
                            bus.busy       <= 1'b1;
                            bus.x_out      <= sum_x[COORD_W-1:0];
                            bus.y_out      <= sum_y[COORD_W-1:0];
                            bus.colour_out <= req_cmd.colour;
                            bus.plot_out   <= in_screen;
                        end
                    end
                end
                DRAW: begin
                    if (last_px) begin
                        state_q      <= IDLE;
                        bus.busy     <= 1'b0;
                        bus.plot_out <= 1'b0;
                    end else begin
                        cx_q           <= nx;
                        cy_q           <= ny;
                        bus.x_out      <= sum_x[COORD_W-1:0];
                        bus.y_out      <= sum_y[COORD_W-1:0];
                        bus.colour_out <= cmd_q.colour;
                        bus.plot_out   <= in_screen;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
